cache_arbiter: RTL and testbench

// - Two-port arbiter between I-cache and D-cache line-fill/writeback ports and the single

---
 rtl/cache_arbiter.sv | 84 ++++++++
 tb/tb_cache_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: grants one of I-cache/D-cache line requests to physical memory and returns the line with a one-cycle resp pulse.
//   Optional build macro ARB_ROUND_ROBIN_EN: alternate ties between clients (default: D-cache wins ties).
//   Ports: clk, rst (async, active-high); i_read/i_address -> i_resp/i_rdata;
//   d_read/d_write/d_address/d_wdata -> d_resp/d_rdata; pmem_read/pmem_write/pmem_address/pmem_wdata <- pmem_resp/pmem_rdata.
module cache_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t state;
   logic owner_d;
   logic win_d;
   logic [LINE_W-1:0] line_q;
   // Both clients see the held line; only the one with resp=1 consumes it.
   assign i_rdata = line_q;
   assign d_rdata = line_q;
`ifdef ARB_ROUND_ROBIN_EN
   logic rr_last;
   always_comb win_d = (d_read | d_write) & (!i_read | !rr_last);
`else
   always_comb win_d = d_read | d_write;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         owner_d      <= 1'b0;
         pmem_read    <= 1'b0;
         pmem_write   <= 1'b0;
         pmem_address <= '0;
         pmem_wdata   <= '0;
         line_q       <= '0;
         i_resp       <= 1'b0;
         d_resp       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_last      <= 1'b0;
`endif
      end else begin
         i_resp <= 1'b0;
         d_resp <= 1'b0;
         case (state)
            IDLE: if (i_read | d_read | d_write) begin
               // Strobes are loaded here so they are already valid throughout BUSY.
               owner_d      <= win_d;
               pmem_read    <= !(win_d & d_write);
               pmem_write   <= win_d & d_write;
               pmem_address <= win_d ? d_address : i_address;
               pmem_wdata   <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
               rr_last      <= win_d;
`endif
               state        <= BUSY;
            end
            BUSY: if (pmem_resp) begin
               line_q     <= pmem_rdata;
               pmem_read  <= 1'b0;
               pmem_write <= 1'b0;
               i_resp     <= !owner_d;
               d_resp     <= owner_d;
               state      <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scoreboard bench for cache_arbiter with a small memory model.
module tb_cache_arbiter;
   logic clk = 0, rst = 1;
   logic i_read = 0, d_read = 0, d_write = 0, pmem_resp = 0;
   logic [15:0] i_address = '0, d_address = '0;
   logic [255:0] d_wdata = '0, pmem_rdata = '0;
   logic i_resp, d_resp, pmem_read, pmem_write;
   logic [255:0] i_rdata, d_rdata, pmem_wdata;
   logic [15:0] pmem_address;
   int n_chk = 0, n_fail = 0;
   typedef struct {bit d; bit wr; logic [15:0] addr; logic [255:0] wdata;} ent_t;
   ent_t sb[$];
   logic [255:0] mem [logic [15:0]];

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit d, input bit wr, input logic [15:0] addr, input logic [255:0] wdata);
      ent_t e;
      e.d = d; e.wr = wr; e.addr = addr; e.wdata = wdata;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   // Waits for the next grant, checks it against the scoreboard, answers from the memory model
   // and checks the resp pulse. rearm restores the owner's request in the following IDLE cycle.
   task automatic serve(input bit rearm, input bit early_drop);
      ent_t e;
      bit ok;
      logic [255:0] rd;
      logic [1:0] sv;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 0, 1);
         return;
      end
      e = sb.pop_front();
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         step();
         ok = pmem_read | pmem_write;
      end
      chk("grant_seen", ok, 1);
      chk("pmem_read", pmem_read, !e.wr);
      chk("pmem_write", pmem_write, e.wr);
      chk("pmem_address", pmem_address, e.addr);
      if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
      sv = e.d ? {d_read, d_write} : {i_read, 1'b0};
      if (early_drop) begin
         if (e.d) begin d_read = 0; d_write = 0; end else i_read = 0;
      end
      rd = e.wr ? {8{32'h0BAD_F00D}} : (mem.exists(e.addr) ? mem[e.addr] : {16{e.addr}});
      if (e.wr) mem[e.addr] = e.wdata;
      step();
      chk("strobe_held", {pmem_read, pmem_write}, {!e.wr, e.wr});
      chk("no_early_resp", {i_resp, d_resp}, 0);
      pmem_resp = 1;
      pmem_rdata = rd;
      step();
      pmem_resp = 0;
      pmem_rdata = '0;
      chk("i_resp", i_resp, !e.d);
      chk("d_resp", d_resp, e.d);
      chk("rdata", e.d ? d_rdata : i_rdata, rd);
      chk("strobes_in_resp", {pmem_read, pmem_write}, 0);
      if (e.d) begin d_read = 0; d_write = 0; end else i_read = 0;
      step();
      chk("idle_strobes", {pmem_read, pmem_write}, 0);
      chk("idle_resp", {i_resp, d_resp}, 0);
      if (rearm) begin
         if (e.d) {d_read, d_write} = sv; else i_read = sv[1];
      end
   endtask

   initial begin
      bit ok;
      logic [255:0] w;
      do_reset();
      rst = 1;
      #1;
      chk("rst_strobes", {pmem_read, pmem_write}, 0);
      chk("rst_resp", {i_resp, d_resp}, 0);
      chk("rst_address", pmem_address, 0);
      chk("rst_wdata", pmem_wdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      step();
      rst = 0;
      step();
      // Stray memory response while idle must be ignored.
      pmem_resp = 1;
      step();
      pmem_resp = 0;
      step();
      chk("stray_resp", {i_resp, d_resp, pmem_read, pmem_write}, 0);
      // Single I read.
      mem[16'h1230] = {32{8'hA5}};
      i_address = 16'h1230; i_read = 1;
      push(0, 0, 16'h1230, '0);
      serve(0, 0);
      // D write then D read of the same line.
      d_address = 16'h0040; d_wdata = {16{16'hDEAD}}; d_write = 1;
      push(1, 1, 16'h0040, {16{16'hDEAD}});
      serve(0, 0);
      d_read = 1;
      push(1, 0, 16'h0040, '0);
      serve(0, 0);
      // Simultaneous I and D requests right after reset: D first in both builds.
      do_reset();
      i_address = 16'h0100; d_address = 16'h0200;
      i_read = 1; d_read = 1;
      push(1, 0, 16'h0200, '0);
      push(0, 0, 16'h0100, '0);
      serve(0, 0);
      serve(0, 0);
      // Four back-to-back ties with both clients re-requesting.
      do_reset();
      i_read = 1; d_read = 1;
`ifdef ARB_ROUND_ROBIN_EN
      push(1, 0, 16'h0200, '0);
      push(0, 0, 16'h0100, '0);
      push(1, 0, 16'h0200, '0);
      push(0, 0, 16'h0100, '0);
      push(1, 0, 16'h0200, '0);
`else
      for (int k = 0; k < 4; k++) push(1, 0, 16'h0200, '0);
      push(0, 0, 16'h0100, '0);
`endif
      for (int k = 0; k < 3; k++) serve(1, 0);
      serve(0, 0);
      serve(0, 0);
      // Read and write together: write wins.
      w = {8{$urandom}};
      d_address = 16'h0080; d_wdata = w; d_read = 1; d_write = 1;
      push(1, 1, 16'h0080, w);
      serve(0, 0);
      // Reset during BUSY of an I read.
      i_address = 16'h0300; i_read = 1;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         step();
         ok = pmem_read;
      end
      chk("rst_case_grant", ok, 1);
      step();
      rst = 1;
      #1;
      chk("async_strobe_drop", pmem_read, 0);
      i_read = 0;
      step();
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("no_resp_after_rst", {i_resp, d_resp, pmem_read}, 0);
      end
      d_address = 16'h0600; d_read = 1;
      push(1, 0, 16'h0600, '0);
      serve(0, 0);
      // D request dropped during BUSY still completes; nothing granted after.
      d_address = 16'h0500; d_read = 1;
      push(1, 0, 16'h0500, '0);
      serve(0, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("no_regrant", {pmem_read, pmem_write, i_resp, d_resp}, 0);
      end
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
